// File: rtl/fetch_ctrl_unit.sv
// Instruction-fetch stage: PC register, instruction-memory handshake FSM and
// the IF/ID pipeline register feeding decode.
module fetch_ctrl_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_pc,
  input  logic        en_ifid,
  input  logic        flush,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] branch_alu,
  input  logic [31:0] branch_pc_jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fsm_pcsrc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr_buf;
  logic [31:0] raw_target;
  logic [31:0] next_target;

  always_comb begin
    raw_target = pc + 32'd4;
    case (pc_sel)
      2'b01:   raw_target = branch_alu;
      2'b10:   raw_target = branch_pc_jump;
      default: raw_target = pc + 32'd4;
    endcase
    next_target = raw_target & ~32'd3;
  end

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;
  assign fsm_pcsrc = (state == ST_READY);

  // PC only moves in READY, i.e. never while a request is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      instr_buf  <= NOP_INSTR;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_gnt && imem_rvalid) begin
            instr_buf <= imem_rdata;
            state     <= ST_READY;
          end else if (imem_gnt) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr_buf <= imem_rdata;
            state     <= ST_READY;
          end
        end
        ST_READY: begin
          if (flush) begin
            ifid_pc    <= pc;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
          end else if (en_ifid) begin
            ifid_pc    <= pc;
            ifid_instr <= instr_buf;
            ifid_valid <= 1'b1;
          end
          if (en_pc) begin
            pc    <= next_target;
            state <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Transaction-level bench for fetch_ctrl_unit: each fetch is described by its
// grant delay, response delay and stall length; expectations follow from that.
module tb_fetch_ctrl_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_pc = 1'b0, en_ifid = 1'b0, flush = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] branch_alu = '0, branch_pc_jump = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        fsm_pcsrc;
  logic [31:0] ifid_pc, ifid_instr;
  logic        ifid_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: architectural values only.
  logic [31:0] m_pc, m_buf, m_ifpc, m_instr;
  logic        m_valid;

  fetch_ctrl_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .en_pc(en_pc), .en_ifid(en_ifid), .flush(flush),
    .pc_sel(pc_sel), .branch_alu(branch_alu), .branch_pc_jump(branch_pc_jump),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .fsm_pcsrc(fsm_pcsrc),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] target(input logic [31:0] pc, input logic [1:0] sel,
                                         input logic [31:0] alu, input logic [31:0] jmp);
    logic [31:0] t;
    if (sel == 2'b01)      t = alu;
    else if (sel == 2'b10) t = jmp;
    else                   t = pc + 32'd4;
    return {t[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_buf = NOP; m_ifpc = '0; m_instr = NOP; m_valid = 1'b0;
  endtask

  // One clock: check outputs for the current cycle, drive inputs, advance model.
  task automatic step(input logic exp_req, input logic exp_ready,
                      input logic gnt, input logic rv, input logic [31:0] rd,
                      input logic epc, input logic eif, input logic fl,
                      input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] jmp);
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    check("imem_addr", imem_addr, m_pc);
    check("fsm_pcsrc", {31'd0, fsm_pcsrc}, {31'd0, exp_ready});
    check("ifid_pc", ifid_pc, m_ifpc);
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
    en_pc = epc; en_ifid = eif; flush = fl;
    pc_sel = sel; branch_alu = alu; branch_pc_jump = jmp;
    if (exp_ready) begin
      if (fl) begin
        m_ifpc = m_pc; m_instr = NOP; m_valid = 1'b0;
      end else if (eif) begin
        m_ifpc = m_pc; m_instr = m_buf; m_valid = 1'b1;
      end
      if (epc) m_pc = target(m_pc, sel, alu, jmp);
    end
    @(negedge clk);
  endtask

  // Noise step for non-READY cycles: control inputs are random and must be ignored.
  task automatic busy(input logic exp_req, input logic gnt, input logic rv, input logic [31:0] rd);
    step(exp_req, 1'b0, gnt, rv, rd, 1'($urandom), 1'($urandom), 1'($urandom),
         2'($urandom), $urandom, $urandom);
  endtask

  task automatic fetch(input int unsigned g, input int unsigned r, input int unsigned s,
                       input logic [31:0] data, input logic st_if, input logic st_fl,
                       input logic f_if, input logic f_fl, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] jmp);
    for (int unsigned i = 0; i < g; i++)
      busy(1'b1, 1'b0, 1'($urandom), $urandom);      // stale rvalid without gnt
    if (r == 0) begin
      busy(1'b1, 1'b1, 1'b1, data);
    end else begin
      busy(1'b1, 1'b1, 1'b0, $urandom);
      for (int unsigned i = 1; i < r; i++) busy(1'b0, 1'($urandom), 1'b0, $urandom);
      busy(1'b0, 1'($urandom), 1'b1, data);
    end
    m_buf = data;
    for (int unsigned i = 0; i < s; i++)
      step(1'b0, 1'b1, 1'($urandom), 1'($urandom), $urandom, 1'b0, st_if, st_fl,
           2'($urandom), $urandom, $urandom);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, f_if, f_fl, sel, alu, jmp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_pcsrc", {31'd0, fsm_pcsrc}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd1);

    // Single-cycle memory, then normal advance.
    fetch(0, 0, 0, 32'h0050_0093, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, '0);
    check("t1_instr", ifid_instr, 32'h0050_0093);
    check("t1_pc", ifid_pc, 32'h0040_0000);
    check("t1_valid", {31'd0, ifid_valid}, 32'd1);
    check("t1_addr", imem_addr, 32'h0040_0004);

    // Slow response, then a two-cycle load-use stall.
    fetch(0, 3, 0, 32'h0011_0113, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, '0);
    fetch(1, 0, 2, 32'h0021_8193, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, '0);
    check("t3_instr", ifid_instr, 32'h0021_8193);
    fetch(0, 1, 0, 32'h0031_8213, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, '0);
    check("t4_pre_addr", imem_addr, 32'h0040_0010);

    // Taken branch with flush.
    fetch(0, 0, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, '0, 32'h0040_0100);
    check("t4_instr", ifid_instr, NOP);
    check("t4_valid", {31'd0, ifid_valid}, 32'd0);
    check("t4_addr", imem_addr, 32'h0040_0100);

    // jalr alignment and pc+4 wrap.
    fetch(0, 0, 0, 32'h0000_8067, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 32'h0040_0203, '0);
    check("t5_addr", imem_addr, 32'h0040_0200);
    fetch(0, 0, 0, 32'h0000_8067, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 32'hFFFF_FFFC, '0);
    fetch(0, 0, 0, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, '0);
    check("t5_wrap", imem_addr, 32'h0000_0000);

    // Reset while waiting, then a stale response.
    busy(1'b1, 1'b1, 1'b0, '0);
    busy(1'b0, 1'b0, 1'b0, '0);
    do_reset();
    busy(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check("t6_addr", imem_addr, RST_PC);
    check("t6_req", {31'd0, imem_req}, 32'd1);
    check("t6_valid", {31'd0, ifid_valid}, 32'd0);
    check("t6_instr", ifid_instr, NOP);
    fetch(0, 0, 0, 32'h0070_0393, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, '0, '0);
    check("t6_fresh", ifid_instr, 32'h0070_0393);

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      fetch($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            $urandom, $urandom);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl_unit.md
Name: fetch_ctrl_unit

Overview:
Instruction-fetch stage of the RISCV-Lite pipeline, directly upstream of the hazard control unit.
- Owns the PC register, the instruction-memory request/response handshake and the IF/ID pipeline register.
- Produces the fetch-complete strobe (fsm_pcsrc) that the hazard unit ANDs into En_PC/En_IFID.
- Consumes the hazard unit's En_PC, En_IFID and PC-source select, plus the flush decision.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) injected into IF/ID on flush/reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en_pc  in  1  PC update enable (hazard unit En_PC, already gated by fsm_pcsrc).
- en_ifid  in  1  IF/ID load enable (hazard unit En_IFID).
- flush  in  1  branch/jump taken; load NOP into IF/ID.
- pc_sel  in  2  next-PC source: 00 next_pc (pc+4), 01 branch_alu, 10 branch_pc_jump, 11 reserved (= 00).
- branch_alu  in  32  ALU-computed target (jalr / AddtoPC).
- branch_pc_jump  in  32  PC-relative target (branch/jal).
- imem_req  out  1  instruction-memory request valid.
- imem_addr  out  32  request address (= pc).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- fsm_pcsrc  out  1  fetched instruction available; PC may advance.
- ifid_pc  out  32  PC of instruction in IF/ID.
- ifid_instr  out  32  instruction in IF/ID.
- ifid_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst=1 at a clk edge): pc=RESET_PC, state=REQ, instr_buf=NOP_INSTR, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0. Outputs are registered or decoded from state: imem_req=1 and fsm_pcsrc=0 in the first cycle after reset.
- FSM states are REQ, WAIT and READY.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt with imem_rvalid in the same cycle, capture imem_rdata and go to READY. On imem_gnt alone, go to WAIT. Otherwise stay in REQ. imem_rvalid without imem_gnt is ignored (stale response).
  - WAIT: imem_req=0. On imem_rvalid, instr_buf<=imem_rdata and go to READY.
  - READY: fsm_pcsrc=1, imem_req=0.
    - en_pc=1: pc<=target, go to REQ.
    - en_pc=0: stall; stay in READY, keep instr_buf, fsm_pcsrc stays 1.
- Target selection by pc_sel: pc+4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000), branch_alu, or branch_pc_jump. Bits [1:0] of the target are forced to 00.
- IF/ID update happens only when state=READY:
  - flush=1 has priority: ifid_instr<=NOP_INSTR, ifid_valid<=0, ifid_pc<=pc. This is independent of en_ifid.
  - Otherwise, en_ifid=1: ifid_pc<=pc, ifid_instr<=instr_buf, ifid_valid<=1.
  - Otherwise IF/ID holds.
- Outside READY, IF/ID holds. en_pc, en_ifid and flush are ignored outside READY.
- Latency: with single-cycle gnt+rvalid, one instruction is issued every 2 cycles (REQ -> READY -> REQ). Each extra memory wait cycle adds one cycle.
- The PC never changes while a request is outstanding, so a redirect cannot orphan a response.
- Reset mid-WAIT: the FSM returns to REQ. Any late rvalid for the abandoned request arrives in REQ without gnt and is dropped.
- rst has priority over every other input.

Test Plan:
1. Reset, then memory with gnt+rvalid in the same cycle returning 0x00500093 for address 0x00400000 -> imem_addr=0x00400000; next cycle fsm_pcsrc=1. With en_pc=en_ifid=1: ifid_instr=0x00500093, ifid_pc=0x00400000, ifid_valid=1, pc=0x00400004.
2. Memory with gnt immediately and rvalid 3 cycles later -> fsm_pcsrc stays 0 through WAIT and rises on the cycle after rvalid. PC advances only after that.
3. Load-use stall: in READY, hold en_pc=0, en_ifid=0 for 2 cycles -> pc, instr_buf and IF/ID unchanged; fsm_pcsrc=1 throughout. Release -> normal advance.
4. Taken branch: in READY with pc=0x00400010, flush=1, en_ifid=0, en_pc=1, pc_sel=10, branch_pc_jump=0x00400100 -> ifid_instr=0x00000013, ifid_valid=0, next imem_addr=0x00400100.
5. jalr: pc_sel=01, branch_alu=0x00400203 -> next imem_addr=0x00400200 (low bits cleared). Separately, pc=0xFFFFFFFC with pc_sel=00 -> next imem_addr=0x00000000.
6. Assert rst during WAIT, then deliver a stale rvalid with 0xDEADBEEF -> pc=0x00400000, 0xDEADBEEF is never captured, IF/ID=NOP with ifid_valid=0, and a fresh request is issued.
